// File: rtl/serial_sub4_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub4_pkg
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the bit-counter width.
//
// Optional feature macro used by the block: SERIAL_SUB4_OVF_EN (adds ovf).
// -----------------------------------------------------------------------------
package serial_sub4_pkg;

   // Default operand/result width; legal range 2..8.
   localparam int DEF_WIDTH = 4;

   // Counter is sized for the largest legal WIDTH (8), so it must hold 0..8.
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage : serial_sub4_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor computing a - b - bin.
//
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow in
//   d    out difference bit
//   bout out borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (bin & ~(a ^ b));

endmodule : full_subtractor

// File: rtl/serial_sub4.sv
// -----------------------------------------------------------------------------
// serial_sub4
// Bit-serial subtractor: computes a - b one bit per enabled clock, LSB first,
// through a single full_subtractor. A start accepted in IDLE takes WIDTH SHIFT
// cycles plus one DONE cycle; d/bout/done update on the edge leaving DONE.
//
// Optional feature: define SERIAL_SUB4_OVF_EN to add the signed overflow
// output ovf, updated together with d.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   ena    in   clock enable; 0 freezes all state
//   start  in   request a subtraction (sampled in IDLE only)
//   a      in   minuend  [WIDTH]
//   b      in   subtrahend [WIDTH]
//   busy   out  high in SHIFT and DONE
//   done   out  one-cycle pulse when d/bout update
//   d      out  (a - b) mod 2^WIDTH [WIDTH]
//   bout   out  borrow out (a < b unsigned)
//   ovf    out  signed overflow (only with SERIAL_SUB4_OVF_EN)
// -----------------------------------------------------------------------------
module serial_sub4
   import serial_sub4_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
`ifdef SERIAL_SUB4_OVF_EN
   output logic             ovf,
`endif
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               borrow_q, borrow_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   d_q, d_d;
   logic               bout_q, bout_d;
   logic               done_q, done_d;
`ifdef SERIAL_SUB4_OVF_EN
   logic               ovf_q, ovf_d;
`endif

   logic               fs_d, fs_bout;

   full_subtractor u_fs (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .bin  (borrow_q),
      .d    (fs_d),
      .bout (fs_bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         d_q      <= '0;
         bout_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIAL_SUB4_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         d_q      <= d_d;
         bout_q   <= bout_d;
         done_q   <= done_d;
`ifdef SERIAL_SUB4_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      d_d      = d_q;
      bout_d   = bout_q;
      done_d   = done_q;
`ifdef SERIAL_SUB4_OVF_EN
      ovf_d    = ovf_q;
`endif
      // With ena low every register keeps its value, done included.
      if (ena) begin
         done_d = 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_sh_d   = a;
                  b_sh_d   = b;
                  borrow_d = 1'b0;
                  cnt_d    = '0;
                  state_d  = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // Operands rotate rather than shift so that after WIDTH steps
               // they are back in place and the original MSBs are still
               // available for the overflow term.
               a_sh_d   = {a_sh_q[0], a_sh_q[WIDTH-1:1]};
               b_sh_d   = {b_sh_q[0], b_sh_q[WIDTH-1:1]};
               res_d    = {fs_d, res_q[WIDTH-1:1]};
               borrow_d = fs_bout;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               d_d     = res_q;
               bout_d  = borrow_q;
               done_d  = 1'b1;
`ifdef SERIAL_SUB4_OVF_EN
               ovf_d   = (a_sh_q[WIDTH-1] != b_sh_q[WIDTH-1]) &&
                         (res_q[WIDTH-1]  != a_sh_q[WIDTH-1]);
`endif
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign d    = d_q;
   assign bout = bout_q;
`ifdef SERIAL_SUB4_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule : serial_sub4

// File: tb/tb_serial_sub4.sv
// -----------------------------------------------------------------------------
// tb_serial_sub4
// Self-checking bench for serial_sub4. A transaction-level model tracks the
// number of enabled edges left for the operation in flight and the result
// computed with plain integer arithmetic; outputs are compared every cycle
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_sub4;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic         ena;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;
`ifdef SERIAL_SUB4_OVF_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;

   // reference model state
   int           rem;
   logic [W-1:0] pend_d, exp_d;
   logic         pend_b, exp_b;
   logic         pend_o, exp_o;
   logic         exp_done;

   serial_sub4 #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
`ifdef SERIAL_SUB4_OVF_EN
      .ovf   (ovf),
`endif
      .done  (done),
      .d     (d),
      .bout  (bout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rem      = 0;
      exp_d    = '0;
      exp_b    = 1'b0;
      exp_o    = 1'b0;
      exp_done = 1'b0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".busy"}, 32'(busy), 32'(rem > 0));
      chk({tag, ".done"}, 32'(done), 32'(exp_done));
      chk({tag, ".d"},    32'(d),    32'(exp_d));
      chk({tag, ".bout"}, 32'(bout), 32'(exp_b));
`ifdef SERIAL_SUB4_OVF_EN
      chk({tag, ".ovf"},  32'(ovf),  32'(exp_o));
`endif
   endtask

   // One clock: model advances on the rising edge using the inputs the DUT
   // sees there; DUT outputs are compared on the following falling edge.
   task automatic cycle(input string tag);
      int sa, sb, r;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else if (ena) begin
         exp_done = 1'b0;
         if (rem > 0) begin
            rem--;
            if (rem == 0) begin
               exp_d    = pend_d;
               exp_b    = pend_b;
               exp_o    = pend_o;
               exp_done = 1'b1;
            end
         end else if (start) begin
            rem    = W + 1;
            pend_d = W'(a - b);
            pend_b = (a < b);
            sa     = $signed(a);
            sb     = $signed(b);
            r      = sa - sb;
            pend_o = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
         end
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   // Issue one operation and run it to completion, scrambling a/b mid-op.
   task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
      a     = av;
      b     = bv;
      start = 1'b1;
      cycle(tag);
      start = 1'b0;
      for (int i = 0; i < W + 1; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         cycle(tag);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      ena   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      model_reset();
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      cycle("idle");

      // directed arithmetic cases
      op(4'd9, 4'd3, "9m3");
      chk("9m3.d_const", 32'(d), 32'd6);
      chk("9m3.b_const", 32'(bout), 32'd0);
      op(4'd3, 4'd9, "3m9");
      chk("3m9.d_const", 32'(d), 32'hA);
      chk("3m9.b_const", 32'(bout), 32'd1);
      op(4'd15, 4'd15, "15m15");
      chk("15m15.d_const", 32'(d), 32'd0);
      op(4'd0, 4'd1, "0m1");
      chk("0m1.d_const", 32'(d), 32'hF);
      chk("0m1.b_const", 32'(bout), 32'd1);
      op(4'd7, 4'd8, "7m8");
      op(4'd6, 4'd2, "6m2");

      // start held high throughout: only starts seen in IDLE are accepted
      start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         cycle("start_hold");
      end
      start = 1'b0;
      for (int i = 0; i < W + 2; i++) cycle("start_drain");

      // reset during SHIFT cycle 2: outputs clear at once, no done
      a = 4'd9; b = 4'd3; start = 1'b1;
      cycle("rst_mid.start");
      start = 1'b0;
      cycle("rst_mid.s1");
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("rst_mid.async");
      cycle("rst_mid.hold");
      @(negedge clk);
      rst_n = 1'b1;
      cycle("rst_mid.rel");
      op(4'd5, 4'd2, "5m2");
      chk("5m2.d_const", 32'(d), 32'd3);

      // ena low for 3 cycles mid-operation
      a = 4'd12; b = 4'd5; start = 1'b1;
      cycle("ena.start");
      start = 1'b0;
      cycle("ena.s1");
      ena = 1'b0;
      for (int i = 0; i < 3; i++) cycle("ena.stall");
      ena = 1'b1;
      for (int i = 0; i < W; i++) cycle("ena.run");
      chk("12m5.done_const", 32'(done), 32'd1);
      chk("12m5.d_const", 32'(d), 32'd7);
      chk("12m5.b_const", 32'(bout), 32'd0);
      cycle("ena.tail");

      // random traffic with random enable and start
      for (int i = 0; i < 400; i++) begin
         ena   = ($urandom_range(0, 3) != 0);
         start = ($urandom_range(0, 2) == 0);
         a     = W'($urandom);
         b     = W'($urandom);
         cycle("rand");
      end
      ena   = 1'b1;
      start = 1'b0;
      for (int i = 0; i < W + 3; i++) cycle("rand_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_sub4

// File: doc/serial_sub4.md
SERIAL_SUB4 -- requirements
Module: serial_sub4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning operand/result width in bits (legal range 2..8).
REQ-002 The block SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port ena  input  1  clock-enable; 0 freezes all state.
REQ-005 The block SHALL have port start  input  1  request a subtraction; sampled only in IDLE.
REQ-006 The block SHALL have port a  input  WIDTH  minuend, captured on accepted start.
REQ-007 The block SHALL have port b  input  WIDTH  subtrahend, captured on accepted start.
REQ-008 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse when d/bout update.
REQ-010 The block SHALL have port d  output  WIDTH  difference a-b modulo 2^WIDTH.
REQ-011 The block SHALL have port bout  output  1  borrow out; 1 when a < b unsigned.

Function
REQ-012 The block SHALL implement states IDLE, SHIFT, DONE; all transitions qualified by ena=1.
REQ-013 IDLE with start=1 SHALL capture a, b into shift registers, clear borrow flop and bit counter, go to SHIFT.
REQ-014 Each SHIFT cycle SHALL subtract one bit pair (LSB first) with borrow-in from the borrow flop, shift the diff bit in at the result MSB, update the borrow flop, increment the counter.
REQ-015 After exactly WIDTH SHIFT cycles the block SHALL go to DONE, loading d and bout from the shift result and final borrow.
REQ-016 DONE SHALL assert done for exactly one cycle and return to IDLE unconditionally.
REQ-017 Latency: start sampled at edge N SHALL produce done=1 and new d/bout after edge N+WIDTH+1.
REQ-018 busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-019 d and bout SHALL hold the previous result during SHIFT and until the next DONE.
REQ-020 start while busy=1 (including the DONE cycle) SHALL be ignored, with no queuing.
REQ-021 Changes on a/b after capture SHALL NOT affect the operation in progress.
REQ-022 ena=0 mid-operation SHALL stall state, counter, borrow and done unchanged; resuming completes correctly.
REQ-023 Arithmetic: d = (a - b) mod 2^WIDTH; bout = (a < b) unsigned; a = b gives d = 0, bout = 0.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, d=0, bout=0, borrow=0, counter=0, in any state.
REQ-025 Reset mid-operation SHALL abandon the operation with no done pulse; the first start after release SHALL behave normally.

Configuration
REQ-026 With macro SERIAL_SUB4_OVF_EN defined, the block SHALL add output ovf (1 bit): signed two's-complement overflow, = (a[MSB]!=b[MSB]) && (d[MSB]!=a[MSB]), updated with d, reset 0.
REQ-027 Without SERIAL_SUB4_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 State encoding (IDLE/SHIFT/DONE) and the default WIDTH constant SHALL reside in shared package serial_sub4_pkg.
REQ-029 The per-bit logic SHALL be sub-module full_subtractor (inputs a, b, bin; outputs d = a^b^bin, bout = (~a&b)|(bin&~(a^b))), instantiated once.

Verification
REQ-030 A=9, B=3, start -> after WIDTH+1 cycles done=1, d=6, bout=0.
REQ-031 A=3, B=9 -> d=0xA, bout=1; A=15, B=15 -> d=0, bout=0; A=0, B=1 -> d=0xF, bout=1.
REQ-032 start pulsed every cycle during busy -> exactly one done per accepted start; inputs changed mid-op ignored.
REQ-033 rst_n low at SHIFT cycle 2 -> outputs 0 immediately, no done; a following 5-2 yields d=3.
REQ-034 ena held 0 for 3 cycles mid-op with A=12, B=5 -> latency +3, d=7, bout=0.
REQ-035 With SERIAL_SUB4_OVF_EN: A=7, B=8 -> d=0xF, bout=1, ovf=1; A=6, B=2 -> ovf=0.
